oam_dma_ctrl: RTL and testbench

- Sprite OAM DMA sequencer between the 6502 core, the CPU memory bus and the PPU OAM.
- Snoops CPU writes to $4014. On a trigger it halts the CPU, takes over the bus, and copies 256 bytes from CPU page $XX00–$XXFF into OAM.
- Bus ownership is handed back after the last OAM write.
- All sequencing advances on the CPU cycle strobe, so timing matches 2A03 DMA (513/514 CPU cycles).

---
 rtl/oam_dma_ctrl.sv | 143 ++++++++++++++
 tb/tb_oam_dma_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl -- sprite OAM DMA sequencer (2A03-style $4014 DMA).
//
// Snoops CPU writes to REG_ADDR. A write latches the source page and the
// starting OAM index, halts the CPU, then copies XFER_LEN bytes from
// {page, 00}..{page, XFER_LEN-1} into OAM as alternating get/put CPU
// cycles. Every state change happens on a ce edge, so the halt lasts
// 1 + align + 2*XFER_LEN CPU cycles.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   ce             one-clk pulse per CPU cycle
//   cpu_wr/addr/wdata  snooped CPU write bus
//   oam_addr_init  current OAMADDR, first OAM index of the transfer
//   cpu_halt       CPU must stall and release the bus
//   dma_bus_en     bus mux selects the DMA address / read strobe
//   dma_addr/dma_rd/dma_rdata  DMA read port (data valid at READ's closing ce)
//   oam_we/oam_addr/oam_wdata  OAM write port (qualify oam_we with ce)
//   busy           transfer in progress
//   done           one-clk pulse after the last OAM write
module oam_dma_ctrl #(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] REG_ADDR = AW'(16'h4014),
    parameter int            XFER_LEN = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic [7:0]    oam_addr_init,
    output logic          cpu_halt,
    output logic          dma_bus_en,
    output logic [AW-1:0] dma_addr,
    output logic          dma_rd,
    input  logic [7:0]    dma_rdata,
    output logic          oam_we,
    output logic [7:0]    oam_addr,
    output logic [7:0]    oam_wdata,
    output logic          busy,
    output logic          done
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t     state;
    logic       parity;   // parity of the CPU cycle in progress: 0 get, 1 put
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] oaddr;
    logic [7:0] idx_nx;

    assign idx_nx = idx + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            parity     <= 1'b0;
            page       <= '0;
            idx        <= '0;
            oaddr      <= '0;
            cpu_halt   <= 1'b0;
            dma_bus_en <= 1'b0;
            dma_addr   <= '0;
            dma_rd     <= 1'b0;
            oam_we     <= 1'b0;
            oam_addr   <= '0;
            oam_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // done is the only output that does not wait for ce
            done <= 1'b0;
            if (ce) begin
                parity <= ~parity;
                case (state)
                    S_IDLE: begin
                        // trigger writes are only honoured here, so a
                        // second write while busy cannot restart the copy
                        if (cpu_wr && cpu_addr == REG_ADDR) begin
                            page     <= cpu_wdata;
                            idx      <= '0;
                            oaddr    <= oam_addr_init;
                            cpu_halt <= 1'b1;
                            busy     <= 1'b1;
                            state    <= S_HALT;
                        end
                    end
                    S_HALT: begin
                        // HALT on a put cycle means the next cycle is a get
                        if (parity) begin
                            state      <= S_READ;
                            dma_bus_en <= 1'b1;
                            dma_rd     <= 1'b1;
                            dma_addr   <= AW'({page, idx});
                        end else begin
                            state <= S_ALIGN;
                        end
                    end
                    S_ALIGN: begin
                        state      <= S_READ;
                        dma_bus_en <= 1'b1;
                        dma_rd     <= 1'b1;
                        dma_addr   <= AW'({page, idx});
                    end
                    S_READ: begin
                        oam_wdata <= dma_rdata;
                        dma_rd    <= 1'b0;
                        oam_we    <= 1'b1;
                        oam_addr  <= oaddr;
                        state     <= S_WRITE;
                    end
                    S_WRITE: begin
                        idx    <= idx_nx;
                        oaddr  <= oaddr + 8'd1;
                        oam_we <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state      <= S_IDLE;
                            done       <= 1'b1;
                            cpu_halt   <= 1'b0;
                            busy       <= 1'b0;
                            dma_bus_en <= 1'b0;
                        end else begin
                            state    <= S_READ;
                            dma_rd   <= 1'b1;
                            dma_addr <= AW'({page, idx_nx});
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: random memory contents, random pages / OAMADDR
// and random ce gaps, checked against expectations computed from the DMA
// rules (address ranges, data copy, halt length from trigger parity).
module tb_oam_dma_ctrl;

    localparam int XL = 256;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  oam_init;
    logic        cpu_halt;
    logic        dma_bus_en;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        busy;
    logic        done;

    oam_dma_ctrl #(.AW(16), .REG_ADDR(16'h4014), .XFER_LEN(XL)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .oam_addr_init(oam_init),
        .cpu_halt(cpu_halt), .dma_bus_en(dma_bus_en),
        .dma_addr(dma_addr), .dma_rd(dma_rd), .dma_rdata(dma_rdata),
        .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
        .busy(busy), .done(done)
    );

    logic [7:0] mem [65536];
    logic [7:0] oam [256];
    assign dma_rdata = mem[dma_addr];

    int checks = 0;
    int errors = 0;

    // CPU cycle index since reset; cycle parity is cyc%2
    int cyc;
    int halt_cnt = 0;
    int done_cnt = 0;
    int rd_q[$];
    int rd_par_q[$];
    int wa_q[$];
    int wd_q[$];

    bit gap_mode = 0;
    int gap_left = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // ce changes 1 time unit after posedge; it marks the upcoming edge
    initial begin
        ce = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!gap_mode) ce = 1;
            else if (gap_left == 0) begin
                ce = 1;
                gap_left = $urandom_range(1, 7);
            end else begin
                ce = 0;
                gap_left--;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else if (ce) cyc <= cyc + 1;
    end

    // monitor mid-cycle: records what each CPU cycle presents at its ce
    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (ce) begin
                if (cpu_halt) halt_cnt++;
                if (dma_rd) begin
                    rd_q.push_back(int'(dma_addr));
                    rd_par_q.push_back(cyc % 2);
                end
                if (oam_we) begin
                    wa_q.push_back(int'(oam_addr));
                    wd_q.push_back(int'(oam_wdata));
                    oam[oam_addr] = oam_wdata;
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // hp: parity the HALT cycle should land on
    task automatic run_xfer(input int pg, input int init, input int hp,
                            input bit inject, input bit abort);
        int rb, wb, db, hb, n, bad_a, bad_d, bad_o, bad_r;
        bit ok, injd;
        rb = rd_q.size(); wb = wa_q.size(); db = done_cnt; hb = halt_cnt;
        oam_init = 8'(init);
        ok = 0; injd = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge clk); #2;
            if (ce && (cyc % 2) == (1 - hp)) begin
                cpu_wr = 1; cpu_addr = 16'h4014; cpu_wdata = 8'(pg);
                @(posedge clk); #2;
                cpu_wr = 0;
                ok = 1;
            end
        end
        chk("trigger_window", int'(ok), 1);
        n = 0;
        while (done_cnt == db && n < 10000) begin
            @(posedge clk); #2;
            n++;
            if (cpu_wr) cpu_wr = 0;
            else if (inject && !injd && ce && (rd_q.size() - rb) >= 50) begin
                cpu_wr = 1; cpu_addr = 16'h4014; cpu_wdata = 8'h05;
                injd = 1;
            end
            if (abort && (wa_q.size() - wb) >= 100) begin
                cpu_wr = 0;
                rst = 1;
                @(posedge clk); #1;
                chk("abort_halt", int'(cpu_halt), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_oam_we", int'(oam_we), 0);
                chk("abort_bus_en", int'(dma_bus_en), 0);
                chk("abort_rd", int'(dma_rd), 0);
                rst = 0;
                return;
            end
        end
        chk("xfer_timeout", int'(n < 10000), 1);
        chk("halt_drop", int'(cpu_halt), 0);
        chk("busy_drop", int'(busy), 0);
        repeat (20) @(posedge clk);
        #2;
        chk("done_once", done_cnt - db, 1);
        chk("halt_cycles", halt_cnt - hb, 1 + (hp == 0 ? 1 : 0) + 2 * XL);
        chk("rd_count", rd_q.size() - rb, XL);
        chk("wr_count", wa_q.size() - wb, XL);
        if (rd_par_q.size() > rb) chk("first_rd_parity", rd_par_q[rb], 0);
        else chk("first_rd_seen", 0, 1);
        bad_r = 0; bad_a = 0; bad_d = 0; bad_o = 0;
        for (int i = 0; i < XL; i++) begin
            if (rb + i >= rd_q.size() || rd_q[rb + i] != pg * 256 + i) bad_r++;
            if (wb + i >= wa_q.size() || wa_q[wb + i] != (init + i) % 256) bad_a++;
            if (wb + i >= wd_q.size() || wd_q[wb + i] != int'(mem[pg * 256 + i])) bad_d++;
            if (oam[(init + i) % 256] != mem[pg * 256 + i]) bad_o++;
        end
        chk("rd_addr_seq", bad_r, 0);
        chk("oam_addr_seq", bad_a, 0);
        chk("oam_data_seq", bad_d, 0);
        chk("oam_contents", bad_o, 0);
    endtask

    initial begin
        int pg;
        rst = 1; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; oam_init = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_halt", int'(cpu_halt), 0);
        chk("rst_bus_en", int'(dma_bus_en), 0);
        chk("rst_rd", int'(dma_rd), 0);
        chk("rst_oam_we", int'(oam_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dma_addr", int'(dma_addr), 0);
        chk("rst_oam_addr", int'(oam_addr), 0);
        chk("rst_oam_wdata", int'(oam_wdata), 0);
        rst = 0;

        // a write to a neighbouring register must not start anything
        @(posedge clk); #2;
        cpu_wr = 1; cpu_addr = 16'h4015; cpu_wdata = 8'h02;
        @(posedge clk); #2;
        cpu_wr = 0;
        repeat (5) @(posedge clk);
        #2;
        chk("other_reg_busy", int'(busy), 0);

        run_xfer(8'h02, 0, 1, 0, 0);               // no align, 513
        run_xfer(8'h02, 0, 0, 0, 0);               // align, 514
        run_xfer(8'h03, 8'hF0, $urandom_range(0, 1), 0, 0);
        chk("oam_f0_pattern", int'(oam[8'hF0]), 8'hA5);
        chk("oam_ef_pattern", int'(oam[8'hEF]), int'(8'hFF ^ 8'hA5));
        run_xfer(8'h07, $urandom_range(0, 255), 1, 1, 0);  // retrigger while busy
        run_xfer(8'h11, 0, 0, 0, 1);               // reset at 100th write
        pg = $urandom_range(0, 255);
        run_xfer(pg, $urandom_range(0, 255), $urandom_range(0, 1), 0, 0);

        gap_mode = 1;
        pg = $urandom_range(0, 255);
        run_xfer(pg, $urandom_range(0, 255), 1, 0, 0);
        pg = $urandom_range(0, 255);
        run_xfer(pg, $urandom_range(0, 255), 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
